// File: rtl/cdb_arbiter_pkg.sv
// Package wrapper giving the shared definitions a named scope.
package cdb_arbiter_pkg;
  `include "sys_defs.svh"
endpackage

// File: rtl/cdb_rr_select.sv
// Round-robin multi-grant selector: scans requests from rr_ptr, wraps at
// NUM_FU, and hands out up to CDB_SZ grants packed into slots in scan order.
module cdb_rr_select #(
  parameter int NUM_FU = 4,
  parameter int CDB_SZ = 2,
  parameter int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0]             req,
  input  logic [PTR_W-1:0]              rr_ptr,
  output logic [NUM_FU-1:0]             grant,
  output logic [CDB_SZ-1:0][NUM_FU-1:0] slot_sel,
  output logic [PTR_W-1:0]              last_idx,
  output logic                          any_grant
);

  // Walk every FU once in round-robin order, filling slots until full.
  always_comb begin
    int idx;
    int cnt;
    grant     = '0;
    slot_sel  = '0;
    last_idx  = '0;
    any_grant = 1'b0;
    cnt       = 0;
    idx       = 0;
    for (int off = 0; off < NUM_FU; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (req[idx] && (cnt < CDB_SZ)) begin
        grant[idx]         = 1'b1;
        slot_sel[cnt][idx] = 1'b1;
        last_idx           = PTR_W'(idx);
        any_grant          = 1'b1;
        cnt                = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/sys_defs.svh
// Shared sizes and packet layouts for the CDB arbiter.
// Included inside cdb_arbiter_pkg so the types become package members.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define NUM_FU 4
`define CDB_SZ 2

localparam int ROBN_W = 5;
localparam int PRN_W  = 6;
localparam int XLEN   = 32;

typedef struct packed {
  logic              valid;
  logic [ROBN_W-1:0] robn;
  logic [PRN_W-1:0]  dest_prn;
  logic [XLEN-1:0]   value;
  logic              branch_taken;
  logic [XLEN-1:0]   target_addr;
} FU_CDB_PACKET;

typedef struct packed {
  logic             valid;
  logic [PRN_W-1:0] dest_prn;
  logic [XLEN-1:0]  value;
} CDB_PACKET;

typedef struct packed {
  logic              executed;
  logic [ROBN_W-1:0] robn;
  logic              branch_taken;
  logic [XLEN-1:0]   target_addr;
} FU_ROB_PACKET;

`endif

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding register per FU, up to CDB_SZ broadcasts per
// cycle chosen round-robin, with squash flushing everything in flight.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = `NUM_FU,
  parameter int CDB_SZ = `CDB_SZ
) (
  input  logic         clock,
  input  logic         reset,
  input  FU_CDB_PACKET fu_result     [NUM_FU],
  output logic [NUM_FU-1:0] fu_ready,
  input  logic         squash,
  output CDB_PACKET    cdb_packet    [CDB_SZ],
  output FU_ROB_PACKET fu_rob_packet [CDB_SZ]
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  FU_CDB_PACKET                 hold [NUM_FU];
  logic [PTR_W-1:0]             rr_ptr;
  logic [NUM_FU-1:0]            req;
  logic [NUM_FU-1:0]            grant;
  logic [CDB_SZ-1:0][NUM_FU-1:0] slot_sel;
  logic [PTR_W-1:0]             last_idx;
  logic                         any_grant;

  // Occupied holds request the bus; squash withdraws every request.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      req[i]      = hold[i].valid & ~squash;
      fu_ready[i] = (~hold[i].valid | grant[i]) & ~squash;
    end
  end

  cdb_rr_select #(
    .NUM_FU (NUM_FU),
    .CDB_SZ (CDB_SZ),
    .PTR_W  (PTR_W)
  ) u_select (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .slot_sel  (slot_sel),
    .last_idx  (last_idx),
    .any_grant (any_grant)
  );

  // Holding registers: refill on handshake, drain on grant, else keep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) hold[i] <= '0;
    end else if (squash) begin
      for (int i = 0; i < NUM_FU; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_result[i].valid && fu_ready[i]) begin
          hold[i] <= fu_result[i];
        end else if (grant[i]) begin
          hold[i] <= '0;
        end
      end
    end
  end

  // Pointer moves just past the last FU served this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  // Mux granted holds into their slots; empty slots stay all-zero.
  always_comb begin
    for (int k = 0; k < CDB_SZ; k++) begin
      cdb_packet[k]    = '0;
      fu_rob_packet[k] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (slot_sel[k][i]) begin
          fu_rob_packet[k].executed     = 1'b1;
          fu_rob_packet[k].robn         = hold[i].robn;
          fu_rob_packet[k].branch_taken = hold[i].branch_taken;
          fu_rob_packet[k].target_addr  = hold[i].target_addr;
          cdb_packet[k].valid           = (hold[i].dest_prn != '0);
          cdb_packet[k].dest_prn        = hold[i].dest_prn;
          cdb_packet[k].value           = hold[i].value;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with NUM_FU=4, CDB_SZ=2.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic         clock;
  logic         reset;
  logic         squash;
  FU_CDB_PACKET fu_result     [4];
  logic [3:0]   fu_ready;
  CDB_PACKET    cdb_packet    [2];
  FU_ROB_PACKET fu_rob_packet [2];

  int total  = 0;
  int passed = 0;

  cdb_arbiter #(.NUM_FU(4), .CDB_SZ(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .fu_result     (fu_result),
    .fu_ready      (fu_ready),
    .squash        (squash),
    .cdb_packet    (cdb_packet),
    .fu_rob_packet (fu_rob_packet)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) fu_result[i] = '0;
  endtask

  task automatic set_fu(input int i, input logic [4:0] robn, input logic [5:0] prn,
                        input logic [31:0] value, input logic bt, input logic [31:0] ta);
    fu_result[i].valid        = 1'b1;
    fu_result[i].robn         = robn;
    fu_result[i].dest_prn     = prn;
    fu_result[i].value        = value;
    fu_result[i].branch_taken = bt;
    fu_result[i].target_addr  = ta;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    clear_inputs();
    #3;
    chk("rst_ready", 64'(fu_ready), 64'h0f);
    chk("rst_exec0", 64'(fu_rob_packet[0].executed), 64'h0);
    chk("rst_cdbv0", 64'(cdb_packet[0].valid), 64'h0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // Idle after reset
    tick();
    chk("idle_ready", 64'(fu_ready), 64'h0f);
    chk("idle_slot0", 64'(fu_rob_packet[0]), 64'h0);
    chk("idle_slot1", 64'(cdb_packet[1]), 64'h0);
    chk("idle_rr", 64'(dut.rr_ptr), 64'h0);

    // Single result from FU1
    set_fu(1, 5'd5, 6'd12, 32'hAB, 1'b0, 32'h0);
    tick();
    clear_inputs();
    #1;
    chk("fu1_exec", 64'(fu_rob_packet[0].executed), 64'h1);
    chk("fu1_robn", 64'(fu_rob_packet[0].robn), 64'h5);
    chk("fu1_cdbv", 64'(cdb_packet[0].valid), 64'h1);
    chk("fu1_prn", 64'(cdb_packet[0].dest_prn), 64'd12);
    chk("fu1_val", 64'(cdb_packet[0].value), 64'hAB);
    chk("fu1_s1rob", 64'(fu_rob_packet[1]), 64'h0);
    chk("fu1_s1cdb", 64'(cdb_packet[1]), 64'h0);
    chk("fu1_rr_pre", 64'(dut.rr_ptr), 64'h0);
    tick();
    chk("fu1_rr", 64'(dut.rr_ptr), 64'h2);
    chk("fu1_drain", 64'(fu_rob_packet[0].executed), 64'h0);

    // Re-home pointer with an asynchronous reset pulse
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("pulse_rr", 64'(dut.rr_ptr), 64'h0);

    // All four FUs at once
    for (int i = 0; i < 4; i++) set_fu(i, 5'(10 + i), 6'(20 + i), 32'(256 + i), 1'b0, 32'h0);
    tick();
    clear_inputs();
    #1;
    chk("all_ready", 64'(fu_ready), 64'h3);
    chk("all_s0robn", 64'(fu_rob_packet[0].robn), 64'd10);
    chk("all_s1robn", 64'(fu_rob_packet[1].robn), 64'd11);
    chk("all_s0val", 64'(cdb_packet[0].value), 64'h100);
    chk("all_s1val", 64'(cdb_packet[1].value), 64'h101);
    tick();
    chk("all2_s0robn", 64'(fu_rob_packet[0].robn), 64'd12);
    chk("all2_s1robn", 64'(fu_rob_packet[1].robn), 64'd13);
    chk("all2_s0val", 64'(cdb_packet[0].value), 64'h102);
    chk("all2_s1prn", 64'(cdb_packet[1].dest_prn), 64'd23);
    chk("all2_ready", 64'(fu_ready), 64'hf);
    tick();
    chk("all_rr", 64'(dut.rr_ptr), 64'h0);
    chk("all_empty", 64'(fu_rob_packet[0].executed), 64'h0);

    // PRN 0 branch result from FU2
    set_fu(2, 5'd7, 6'd0, 32'h55, 1'b1, 32'h40);
    tick();
    clear_inputs();
    #1;
    chk("p0_exec", 64'(fu_rob_packet[0].executed), 64'h1);
    chk("p0_robn", 64'(fu_rob_packet[0].robn), 64'd7);
    chk("p0_bt", 64'(fu_rob_packet[0].branch_taken), 64'h1);
    chk("p0_ta", 64'(fu_rob_packet[0].target_addr), 64'h40);
    chk("p0_cdbv", 64'(cdb_packet[0].valid), 64'h0);
    tick();
    chk("p0_rr", 64'(dut.rr_ptr), 64'h3);

    // Squash with FU0 and FU3 occupied
    set_fu(0, 5'd1, 6'd3, 32'h11, 1'b0, 32'h0);
    set_fu(3, 5'd2, 6'd4, 32'h22, 1'b0, 32'h0);
    tick();
    clear_inputs();
    set_fu(1, 5'd9, 6'd9, 32'h99, 1'b0, 32'h0);
    squash = 1'b1;
    #1;
    chk("sq_ready", 64'(fu_ready), 64'h0);
    chk("sq_rob0", 64'(fu_rob_packet[0]), 64'h0);
    chk("sq_cdb1", 64'(cdb_packet[1]), 64'h0);
    tick();
    squash = 1'b0;
    clear_inputs();
    #1;
    chk("sq_after_ready", 64'(fu_ready), 64'hf);
    chk("sq_after_exec", 64'(fu_rob_packet[0].executed), 64'h0);
    chk("sq_after_rr", 64'(dut.rr_ptr), 64'h3);

    // Back-to-back stream on FU0
    set_fu(0, 5'd0, 6'd30, 32'h200, 1'b0, 32'h0);
    tick();
    for (int n = 1; n < 6; n++) begin
      set_fu(0, 5'(n), 6'd30, 32'(512 + n), 1'b0, 32'h0);
      #1;
      chk("b2b_ready0", 64'(fu_ready[0]), 64'h1);
      chk("b2b_val", 64'(cdb_packet[0].value), 64'(512 + n - 1));
      chk("b2b_robn", 64'(fu_rob_packet[0].robn), 64'(n - 1));
      tick();
    end
    clear_inputs();
    #1;
    chk("b2b_last", 64'(cdb_packet[0].value), 64'h205);
    tick();
    chk("b2b_drain", 64'(fu_rob_packet[0].executed), 64'h0);

    // Reset mid-operation discards held results without a clock edge
    set_fu(1, 5'd3, 6'd5, 32'h33, 1'b0, 32'h0);
    set_fu(2, 5'd4, 6'd6, 32'h44, 1'b0, 32'h0);
    tick();
    clear_inputs();
    #1;
    chk("mr_pre_exec", 64'(fu_rob_packet[1].executed), 64'h1);
    reset = 1'b1;
    #1;
    chk("mr_exec0", 64'(fu_rob_packet[0].executed), 64'h0);
    chk("mr_cdbv1", 64'(cdb_packet[1].valid), 64'h0);
    chk("mr_ready", 64'(fu_ready), 64'hf);
    chk("mr_rr", 64'(dut.rr_ptr), 64'h0);
    reset = 1'b0;
    tick();
    chk("mr_after", 64'(fu_rob_packet[0].executed), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default `NUM_FU: number of functional-unit result sources.
REQ-002 SHALL have parameter CDB_SZ, default `CDB_SZ: broadcast slots per cycle.
REQ-003 clock  input  1  single clock for all state.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 fu_result  input  FU_CDB_PACKET[NUM_FU]  per-FU result: valid, robn, dest_prn, value, branch_taken, target_addr.
REQ-006 fu_ready  output  NUM_FU  per-FU ready; a result transfers when valid and ready are both high at a rising edge.
REQ-007 squash  input  1  mispredict flush from the ROB, same cycle.
REQ-008 cdb_packet  output  CDB_PACKET[CDB_SZ]  register broadcast: valid, dest_prn, value.
REQ-009 fu_rob_packet  output  FU_ROB_PACKET[CDB_SZ]  completion to the ROB: executed, robn, branch_taken, target_addr.

Function
REQ-010 SHALL hold one holding register (hold_valid plus payload) per FU.
REQ-011 Latency: a result accepted at edge t SHALL be eligible for broadcast in the cycle after t. There is no same-cycle bypass.
REQ-012 Each cycle, SHALL grant up to CDB_SZ occupied holding registers.
REQ-013 Grant scan: round-robin order starting at FU index rr_ptr, wrapping at NUM_FU.
REQ-014 Packing: granted FUs SHALL fill slots 0,1,... in scan order. Unused slots SHALL be all-zero.
REQ-015 fu_rob_packet[k].executed SHALL be 1 for every filled slot.
REQ-016 cdb_packet[k].valid SHALL be 1 only if the slot is filled and dest_prn != 0. A PRN 0 result completes in the ROB but SHALL NOT broadcast a register write.
REQ-017 fu_ready[i] SHALL be combinational: (~hold_valid[i] | granted[i]) & ~squash.
REQ-018 A granted holding register SHALL be refilled in the same cycle when an input handshake occurs on that FU. The hold stays occupied, so back-to-back results from one FU are possible.
REQ-019 On a granted holding register with no handshake, SHALL clear hold_valid at the next edge.
REQ-020 On an ungranted occupied holding register, SHALL retain its payload unchanged; fu_ready is low.
REQ-021 rr_ptr SHALL advance to (last granted index + 1) mod NUM_FU. It SHALL stay unchanged if nothing is granted.
REQ-022 Squash cycle:
  - all outputs zero;
  - all fu_ready low;
  - all holding registers cleared at the next edge;
  - input results dropped;
  - rr_ptr unchanged.
REQ-023 When fewer than CDB_SZ holds are occupied, SHALL grant all of them with no starvation.
REQ-024 Fairness: with more than CDB_SZ holds occupied continuously, an occupied hold SHALL be granted within ceil(NUM_FU/CDB_SZ) cycles.
REQ-025 robn and all payload fields SHALL pass through unmodified. There is no arithmetic on payload.

Reset
REQ-026 While reset is high, SHALL hold:
  - all hold_valid = 0;
  - all payloads = 0;
  - rr_ptr = 0;
  - all cdb_packet and fu_rob_packet = 0;
  - fu_ready = all ones (subject to squash).
REQ-027 Reset asserted mid-operation SHALL discard all buffered results immediately, without waiting for a clock edge.

Structure
REQ-028 FU_CDB_PACKET, CDB_PACKET and FU_ROB_PACKET SHALL be defined in sys_defs.svh, alongside `NUM_FU and `CDB_SZ.
REQ-029 The rr_ptr width SHALL be $clog2(NUM_FU), defined locally.
REQ-030 The round-robin multi-grant selector SHALL be a sub-module cdb_rr_select:
  - inputs: request vector, rr_ptr;
  - outputs: grant vector and per-slot one-hot FU index.

Verification (bench: NUM_FU=4, CDB_SZ=2)
REQ-031 Reset release, no inputs -> all outputs zero, fu_ready=4'b1111, rr_ptr=0.
REQ-032 FU1 robn=5, dest_prn=12, value=0xAB at edge t -> cycle t+1:
  - slot0 fu_rob executed=1, robn=5;
  - slot0 cdb valid=1, dest_prn=12, value=0xAB;
  - slot1 zero;
  - rr_ptr becomes 2.
REQ-033 All four FUs valid for one cycle, rr_ptr=0 -> next cycle FU0,FU1 broadcast and fu_ready=4'b0011. The following cycle FU2,FU3 broadcast.
REQ-034 FU2 result with dest_prn=0 and branch_taken=1, target_addr=0x40 -> fu_rob_packet executed=1 with those fields; cdb_packet.valid=0.
REQ-035 FU0 and FU3 holds occupied, squash=1 -> that cycle outputs zero and fu_ready=0. Next cycle all holds empty and no broadcast.
REQ-036 FU0 valid every cycle with the hold granted each cycle -> fu_ready[0] stays 1 and one result broadcasts per cycle with no bubble.
